decode_queue: RTL
=================

# decode_queue

Buffered, parametrised decode stage for the refcpu core. Accepts fetched instruction words over a valid/ready handshake and classifies each by opcode/funct into an instruction class. It also forms the 32-bit extended immediate and holds the decoded entries in a DEPTH-entry FIFO until execute pops them. It sits between fetch and the execute state machine and supports flush on control-flow redirect.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- PC_W, 32: PC width.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  discard all queued entries and any same-cycle input.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept; = !full && !reset.
- in_pc  in  PC_W  PC of presented instruction.
- in_instr  in  32  instruction word.
- out_valid  out  1  head entry valid; = !empty.
- out_ready  in  1  execute consumes head.
- out_pc  out  PC_W  head PC.
- out_instr  out  32  head instruction word.
- out_cls  out  3  head class code.
- out_imm  out  32  head extended immediate.
- out_count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Class codes: 0 RTYPE, 1 BRANCH, 2 UARITH, 3 LOAD, 4 STORE, 5 JUMP, 6 MULDIV, 7 UNKNOWN.
- Opcode map:
  - 000000 → RTYPE.
  - 000100 BEQ, 000101 BNE → BRANCH.
  - 001001 ADDIU, 001100 ANDI, 001101 ORI, 001110 XORI, 001111 LUI → UARITH.
  - 100011 LW → LOAD.
  - 101011 SW → STORE.
  - 000010 J, 000011 JAL → JUMP.
  - Anything else → UNKNOWN.
- MULDIV: opcode 000000 with funct 011000–011011 (MULT/MULTU/DIV/DIVU); see Configuration.
- Immediate rules, instr[15:0] = imm16:
  - ANDI/ORI/XORI: zero-extend.
  - LUI: imm16 << 16, low half zero.
  - BEQ/BNE/ADDIU/LW/SW: sign-extend.
  - J/JAL: {6'b0, instr[25:0]}.
  - RTYPE/MULDIV/UNKNOWN: 0.
- Decode is combinational on the input side. The decoded result, PC and word are written into the FIFO on push; outputs are driven from the head register, not from the input.
- Push: in_valid && in_ready && !flush.
- Pop: out_valid && out_ready && !flush.
- Push and pop in the same cycle: both take effect, count unchanged. Permitted when not full and not empty.
- When full, in_ready = 0 even if a pop occurs that cycle; there is no bypass.
- Flush: next edge sets count, read pointer and write pointer to 0. Flush overrides push and pop in the same cycle, and out_valid falls the cycle after.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Count is separate, range 0..DEPTH.
- Storage contents are not reset; only pointers and count are.
- out_* data are don't-care while out_valid = 0.

## Timing
- Reset (asynchronous): count = 0, pointers = 0. Immediately out_valid = 0, in_ready = 0, out_count = 0.
- First cycle after reset deasserts: in_ready = 1.
- Latency: instruction pushed at edge n is visible at the head after edge n with out_valid = 1, when the queue was empty.
- Throughput: 1 push + 1 pop per cycle sustained.
- Reset mid-operation: all queued entries are lost. No partial pop is visible.
- Flush with in_valid = 1: the instruction is dropped. Fetch must re-present it after the redirect.

## Configuration
- DECODE_MULDIV_EN defined: RTYPE funct 011000–011011 decode as MULDIV (class 6).
- DECODE_MULDIV_EN undefined:
  - Those encodings decode as UNKNOWN (class 7), so execute traps them.
  - Class 6 is never produced.
  - All other behaviour is identical.

## Test plan
- Reset, then push ORI word 0x3421_8001 at pc 0x1000 → next cycle out_valid = 1, out_cls = 2, out_imm = 0x0000_8001, out_pc = 0x1000.
- Push ADDIU 0x2421_FFFF and then LUI 0x3C01_1234 back-to-back, popping every cycle:
  - ADDIU → out_imm = 0xFFFF_FFFF.
  - LUI → out_imm = 0x1234_0000.
  - out_count stays ≤ 1.
- Fill with DEPTH = 4 words while out_ready = 0:
  - in_ready = 0 after the 4th push and out_count = 4.
  - A 5th in_valid is not accepted.
  - Pop 4 → order preserved and pointers wrap correctly on the next fill.
- Queue holding 3 entries, flush asserted with in_valid = 1 and out_ready = 1 → next cycle out_count = 0, out_valid = 0, nothing popped or pushed.
- Word 0x0041_0018 (MULT):
  - out_cls = 6 with DECODE_MULDIV_EN defined.
  - out_cls = 7 without it.
  - Opcode 0x3F word → out_cls = 7 in both builds.
- Assert reset asynchronously mid-stream with 2 entries queued → out_valid and in_ready fall without a clock edge. After release, queue empty and in_ready = 1.

Source files
------------

// File: rtl/decode_queue.sv
// decode_queue: decode stage for the refcpu core.
// Classifies incoming instruction words by opcode/funct, forms the 32-bit
// extended immediate and buffers the decoded entries in a DEPTH-entry FIFO
// until execute pops them. A flush discards everything, including any
// instruction presented in the same cycle.
//
// Optional feature macro: DECODE_MULDIV_EN
//   defined   -> RTYPE funct 011000..011011 decode as MULDIV (class 6)
//   undefined -> those encodings decode as UNKNOWN (class 7)

module decode_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_W  = 32
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [PC_W-1:0]              in_pc_i,
    input  logic [31:0]                  in_instr_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [PC_W-1:0]              out_pc_o,
    output logic [31:0]                  out_instr_o,
    output logic [2:0]                   out_cls_o,
    output logic [31:0]                  out_imm_o,
    output logic [$clog2(DEPTH+1)-1:0]   out_count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [2:0] CLS_RTYPE   = 3'd0;
    localparam logic [2:0] CLS_BRANCH  = 3'd1;
    localparam logic [2:0] CLS_UARITH  = 3'd2;
    localparam logic [2:0] CLS_LOAD    = 3'd3;
    localparam logic [2:0] CLS_STORE   = 3'd4;
    localparam logic [2:0] CLS_JUMP    = 3'd5;
    localparam logic [2:0] CLS_MULDIV  = 3'd6;
    localparam logic [2:0] CLS_UNKNOWN = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    // Pointers wrap by natural overflow, so DEPTH must be a power of two.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("decode_queue: DEPTH must be a power of two and at least 2");
    end

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
        logic [2:0]      cls;
        logic [31:0]     imm;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             entry_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [15:0]        imm16;
    logic [31:0]        imm_sext;
    logic [31:0]        imm_zext;
    logic [2:0]         cls_d;
    logic [31:0]        imm_d;

    assign opcode   = in_instr_i[31:26];
    assign funct    = in_instr_i[5:0];
    assign imm16    = in_instr_i[15:0];
    assign imm_sext = {{16{imm16[15]}}, imm16};
    assign imm_zext = {16'h0000, imm16};

    // Combinational decode of the presented word into class and immediate.
    always_comb begin
        cls_d = CLS_UNKNOWN;
        imm_d = 32'h0000_0000;
        unique case (opcode)
            OP_RTYPE: begin
                if (funct == FN_MULT || funct == FN_MULTU ||
                    funct == FN_DIV  || funct == FN_DIVU) begin
`ifdef DECODE_MULDIV_EN
                    cls_d = CLS_MULDIV;
`else
                    cls_d = CLS_UNKNOWN;
`endif
                end else begin
                    cls_d = CLS_RTYPE;
                end
            end
            OP_BEQ, OP_BNE: begin
                cls_d = CLS_BRANCH;
                imm_d = imm_sext;
            end
            OP_ADDIU: begin
                cls_d = CLS_UARITH;
                imm_d = imm_sext;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                cls_d = CLS_UARITH;
                imm_d = imm_zext;
            end
            OP_LUI: begin
                cls_d = CLS_UARITH;
                imm_d = {imm16, 16'h0000};
            end
            OP_LW: begin
                cls_d = CLS_LOAD;
                imm_d = imm_sext;
            end
            OP_SW: begin
                cls_d = CLS_STORE;
                imm_d = imm_sext;
            end
            OP_J, OP_JAL: begin
                cls_d = CLS_JUMP;
                imm_d = {6'b000000, in_instr_i[25:0]};
            end
            default: begin
                cls_d = CLS_UNKNOWN;
                imm_d = 32'h0000_0000;
            end
        endcase
    end

    // Assemble the entry written into storage on push.
    always_comb begin
        entry_d.pc    = in_pc_i;
        entry_d.instr = in_instr_i;
        entry_d.cls   = cls_d;
        entry_d.imm   = imm_d;
    end

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == CNT_W'(0));
    // Ready drops immediately while reset is held, not only after it clears the count.
    assign in_ready_o  = !full && !reset_i;
    assign out_valid_o = !empty;
    assign push = in_valid_i && in_ready_o && !flush_i;
    assign pop  = out_valid_o && out_ready_i && !flush_i;

    // Next-state for pointers and occupancy; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers; only these are reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents survive reset and are qualified by out_valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry_d;
        end
    end

    assign out_pc_o    = mem_q[rd_ptr_q].pc;
    assign out_instr_o = mem_q[rd_ptr_q].instr;
    assign out_cls_o   = mem_q[rd_ptr_q].cls;
    assign out_imm_o   = mem_q[rd_ptr_q].imm;
    assign out_count_o = count_q;

endmodule
